// File: rtl/avalon_pio_out_blink.sv
// Avalon-MM output port with atomic set/clear aliases and per-bit blink gating.
// A shared prescaler phase blanks every blink-enabled bit while the phase is low.
module avalon_pio_out_blink #(
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
    parameter int                    CNT_WIDTH      = 24,
    parameter logic [CNT_WIDTH-1:0]  DEFAULT_PERIOD = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic                  wr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] blink_en;
    logic [CNT_WIDTH-1:0]  period;
    logic [CNT_WIDTH-1:0]  count;
    logic                  phase;
    logic                  restart;
    logic                  unused_wdata;

    assign wr      = chipselect & ~write_n;
    assign restart = wr & ((address == 3'd2) | (address == 3'd3));

    // Only the low bits of writedata reach the registers.
    assign unused_wdata = &{1'b0, writedata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data     <= RESET_VALUE;
            blink_en <= '0;
            period   <= DEFAULT_PERIOD;
            count    <= '0;
            phase    <= 1'b1;
            out_port <= RESET_VALUE;
        end else begin
            if (wr) begin
                case (address)
                    3'd0: data     <= writedata[DATA_WIDTH-1:0];
                    3'd1: blink_en <= writedata[DATA_WIDTH-1:0];
                    3'd2: begin
                        period <= writedata[CNT_WIDTH-1:0];
                        count  <= '0;
                    end
                    3'd3: begin
                        count <= '0;
                        phase <= 1'b1;
                    end
                    3'd4: data <= data | writedata[DATA_WIDTH-1:0];
                    3'd5: data <= data & ~writedata[DATA_WIDTH-1:0];
                    default: ;
                endcase
            end

            if (!restart) begin
                if (period == '0) begin
                    count <= '0;
                    phase <= 1'b1;
                end else if (count >= period) begin
                    // >= also catches a period lowered below the running count
                    count <= '0;
                    phase <= ~phase;
                end else begin
                    count <= count + 1'b1;
                end
            end

            out_port <= data & ~(blink_en & {DATA_WIDTH{~phase}});
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            3'd0: readdata[DATA_WIDTH-1:0] = data;
            3'd1: readdata[DATA_WIDTH-1:0] = blink_en;
            3'd2: readdata[CNT_WIDTH-1:0]  = period;
            3'd3: readdata[0]              = phase;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_avalon_pio_out_blink.sv
// Directed bench for avalon_pio_out_blink: register map, set/clear, blink timing, reset.
module tb_avalon_pio_out_blink;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_total;
    int n_bad;

    avalon_pio_out_blink #(
        .DATA_WIDTH    (8),
        .RESET_VALUE   (8'hA5),
        .CNT_WIDTH     (24),
        .DEFAULT_PERIOD(24'd0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    logic [31:0] r;
    logic        ph_prev;
    logic        ph_now;

    initial begin
        n_total    = 0;
        n_bad      = 0;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;

        // reset state, during and after reset
        @(posedge clk);
        #1;
        chk("rst_oport", {24'h0, out_port}, 32'hA5);
        rd_reg(3'd0, r); chk("rst_rd0", r, 32'h0000_00A5);
        rd_reg(3'd1, r); chk("rst_rd1", r, 32'h0);
        rd_reg(3'd3, r); chk("rst_rd3", r, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_oport", {24'h0, out_port}, 32'hA5);
        rd_reg(3'd2, r); chk("rst_rd2", r, 32'h0);
        rd_reg(3'd6, r); chk("rst_rd6", r, 32'h0);

        // DATA write, upper bits dropped, one-cycle output lag
        wr_reg(3'd0, 32'hFFFF_FF3C);
        rd_reg(3'd0, r); chk("data_rd", r, 32'h3C);
        chk("data_oport_lag", {24'h0, out_port}, 32'hA5);
        @(posedge clk); #1;
        chk("data_oport", {24'h0, out_port}, 32'h3C);

        // OUTSET / OUTCLR
        wr_reg(3'd4, 32'h03);
        rd_reg(3'd0, r); chk("set_rd0", r, 32'h3F);
        rd_reg(3'd4, r); chk("set_rd4", r, 32'h0);
        chk("set_oport_lag", {24'h0, out_port}, 32'h3C);
        @(posedge clk); #1;
        chk("set_oport", {24'h0, out_port}, 32'h3F);
        wr_reg(3'd5, 32'h0C);
        rd_reg(3'd0, r); chk("clr_rd0", r, 32'h33);
        rd_reg(3'd5, r); chk("clr_rd5", r, 32'h0);
        chk("clr_oport_lag", {24'h0, out_port}, 32'h3F);
        @(posedge clk); #1;
        chk("clr_oport", {24'h0, out_port}, 32'h33);

        // reserved write ignored
        wr_reg(3'd7, 32'hFFFF_FFFF);
        rd_reg(3'd0, r); chk("rsv_rd0", r, 32'h33);
        rd_reg(3'd1, r); chk("rsv_rd1", r, 32'h0);

        // blink: period 3 -> phase toggles every 4 edges after the PERIOD write
        wr_reg(3'd0, 32'hFF);
        wr_reg(3'd1, 32'h0F);
        wr_reg(3'd2, 32'h3);
        rd_reg(3'd1, r); chk("blk_rd1", r, 32'h0F);
        rd_reg(3'd2, r); chk("blk_rd2", r, 32'h3);
        rd_reg(3'd3, r); chk("blk_ph0", r, 32'h1);
        address    = 3'd3;
        chipselect = 1'b1;
        write_n    = 1'b1;
        ph_prev    = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            ph_now = (((i / 4) % 2) == 0);
            chk($sformatf("blk_ph%0d", i), readdata, {31'h0, ph_now});
            chk($sformatf("blk_op%0d", i), {24'h0, out_port}, ph_prev ? 32'hFF : 32'hF0);
            ph_prev = ph_now;
        end
        chipselect = 1'b0;

        // shrink period by a write: count restarts, wrap 3 edges later
        wr_reg(3'd3, 32'h0);
        wr_reg(3'd2, 32'd10);
        repeat (8) @(posedge clk);
        #1;
        chk("cnt8", {8'h0, dut.count}, 32'd8);
        wr_reg(3'd2, 32'd2);
        chk("wr_cnt0", {8'h0, dut.count}, 32'd0);
        rd_reg(3'd3, r); chk("wr_ph_q0", r, 32'h1);
        @(posedge clk); #1;
        rd_reg(3'd3, r); chk("wr_ph_q1", r, 32'h1);
        @(posedge clk); #1;
        rd_reg(3'd3, r); chk("wr_ph_q2", r, 32'h1);
        @(posedge clk); #1;
        rd_reg(3'd3, r); chk("wr_ph_q3", r, 32'h0);
        chk("wr_cnt_q3", {8'h0, dut.count}, 32'd0);

        // period dropped below count without a write: >= wraps next edge
        wr_reg(3'd3, 32'h0);
        wr_reg(3'd2, 32'd10);
        repeat (8) @(posedge clk);
        #1;
        chk("bd_cnt8", {8'h0, dut.count}, 32'd8);
        force dut.period = 24'd2;
        @(posedge clk); #1;
        chk("bd_cnt0", {8'h0, dut.count}, 32'd0);
        rd_reg(3'd3, r); chk("bd_ph", r, 32'h0);
        release dut.period;

        // reset mid-blink with phase low
        wr_reg(3'd2, 32'h3);
        wr_reg(3'd3, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        chk("mb_oport", {24'h0, out_port}, 32'hF0);
        rd_reg(3'd3, r); chk("mb_ph", r, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("mb_rst_oport", {24'h0, out_port}, 32'hA5);
        rd_reg(3'd3, r); chk("mb_rst_ph", r, 32'h1);
        address    = 3'd0;
        writedata  = 32'h11;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd_reg(3'd0, r); chk("mb_wr_dropped", r, 32'hA5);
        rd_reg(3'd1, r); chk("mb_blk_en", r, 32'h0);
        rd_reg(3'd2, r); chk("mb_period", r, 32'h0);
        rd_reg(3'd3, r); chk("mb_ph_rel", r, 32'h1);
        @(posedge clk); #1;
        chk("mb_oport_rel", {24'h0, out_port}, 32'hA5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/avalon_pio_out_blink.md
Name: avalon_pio_out_blink

Overview:
- Parametrised Avalon-MM slave output port that drives board LEDs or GPIO outputs.
- Provides an output data register plus write-only atomic set and clear aliases.
- Any bit can be switched to blink mode. In blink mode the bit is gated by a shared phase signal from a programmable prescaler.
- Sits on the system interconnect as a drop-in replacement for the fixed 8-bit output PIO; out_port connects straight to the pins.

Parameters:
- DATA_WIDTH, 8, width of out_port and of the data and blink-enable registers (1..32).
- RESET_VALUE, 0, reset value of the data register and of out_port (DATA_WIDTH bits).
- CNT_WIDTH, 24, width of the period register and prescaler counter (1..32).
- DEFAULT_PERIOD, 0, reset value of the period register.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous active-high reset
- address  in  3  word address of register
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data; bits above the target register width are ignored
- readdata  out  32  combinational read data, zero-extended
- out_port  out  DATA_WIDTH  registered pin output

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Write strobe: wr = chipselect & ~write_n. Register writes take effect on the clk edge where wr=1. No wait states.
- Register map:
  - 0 DATA (RW): data <= writedata[DATA_WIDTH-1:0].
  - 1 BLINK_EN (RW): blink_en <= writedata[DATA_WIDTH-1:0].
  - 2 PERIOD (RW): period <= writedata[CNT_WIDTH-1:0]; also count <= 0; phase is unchanged.
  - 3 STATUS: read returns {phase in bit 0}, rest zero. Any write restarts the prescaler: count <= 0, phase <= 1.
  - 4 OUTSET (WO): data <= data | writedata[DATA_WIDTH-1:0]. Reads 0.
  - 5 OUTCLR (WO): data <= data & ~writedata[DATA_WIDTH-1:0]. Reads 0.
  - 6, 7: reserved; writes ignored, reads 0.
- Readdata: purely combinational from address and current register state, same cycle, zero latency. It is a don't-care when chipselect=0 but must still be decoded with no X.
- Prescaler, evaluated each edge when there is no PERIOD or STATUS write in that cycle:
  - period==0: count <= 0, phase <= 1 (blink frozen, blinking bits follow data).
  - else if count >= period: count <= 0, phase <= ~phase.
  - else count <= count + 1.
  - Result: phase toggles every period+1 cycles. The >= compare covers a period reduced below the current count.
- Priority: a PERIOD or STATUS write overrides prescaler counting in that cycle. Only one register is written per cycle.
- Output: out_port <= data & ~(blink_en & {DATA_WIDTH{~phase}}), registered every edge.
  - out_port reflects register state one cycle after it changes.
  - A DATA write at edge k appears on out_port at edge k+1.
- Reset (asserted at any time, including mid-blink or mid-write):
  - data = RESET_VALUE, blink_en = 0, period = DEFAULT_PERIOD, count = 0, phase = 1, out_port = RESET_VALUE.
  - readdata follows the reset register values immediately.
  - A write coinciding with reset is discarded.

Test Plan:
- Reset with DATA_WIDTH=8, RESET_VALUE=8'hA5 -> out_port=A5 during and after reset; read addr0=0x000000A5, addr1=0, addr3=0x1.
- Write addr0=0xFFFFFF3C -> addr0 reads 0x3C next cycle; out_port=3C one cycle after the write edge.
- Write addr4=0x03, then addr5=0x0C -> data 3C->3F->33; out_port follows with 1-cycle lag; addr4 and addr5 read 0.
- data=0xFF, blink_en=0x0F, period=3 -> out_port low nibble alternates F/0 every 4 cycles; high nibble stays F; addr3 bit 0 tracks phase.
- Write period=10, run count to 8, write period=2 -> count restarts at 0 and phase toggles after 3 cycles. Separately, with count=8 and period already 10, change period to 2 via a backdoor force -> wrap on the next edge.
- Assert reset mid-blink with phase=0 -> out_port=RESET_VALUE immediately (asynchronous); after release phase=1 and blink_en=0.
